// File: rtl/fifo_drain.sv
// fifo_drain: reads a burst of words from a show-ahead upstream FIFO into a
// two-entry output buffer and presents them downstream with valid/ready flow
// control.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   start       begin a burst (sampled only in IDLE)
//   burst_len   words to read, sampled with start (0 -> straight to DONE)
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream head word, valid whenever fifo_empty==0
//   fifo_pop    combinational pop strobe to the upstream FIFO
//   out_valid   out_data holds a word
//   out_ready   downstream can accept a word
//   out_data    head of the output buffer (0 when the buffer is empty)
//   busy        high in RUN and DRAIN
//   done        one-cycle pulse at burst completion
//   count       words delivered downstream in the current burst
//   dbg_state   current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a word moves downstream on every rising edge where
// out_valid==1 and out_ready==1. While out_valid==1 and out_ready==0 the
// presented word is held unchanged. out_valid never depends on out_ready.
module fifo_drain #(
  parameter int WIDTH  = 8,
  parameter int LENWID = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENWID-1:0] burst_len,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic [LENWID-1:0] count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LENWID-1:0] L_ONE = {{(LENWID-1){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic [LENWID-1:0] r_remaining, w_remaining_nxt;
  logic [LENWID-1:0] r_count, w_count_nxt;
  logic [1:0]        r_occ, w_occ_nxt;
  // r_head is the oldest word, r_tail the second. Unoccupied entries are
  // kept at zero so a shift from tail into head clears naturally.
  logic [WIDTH-1:0]  r_head, w_head_nxt;
  logic [WIDTH-1:0]  r_tail, w_tail_nxt;
  logic              w_xfer;

  always_comb begin
    fifo_pop  = (r_state == S_RUN) & ~fifo_empty & (r_remaining != '0) & (r_occ < 2'd2);
    out_valid = (r_occ != 2'd0);
    out_data  = out_valid ? r_head : '0;
    w_xfer    = out_valid & out_ready;
    busy      = (r_state == S_RUN) | (r_state == S_DRAIN);
    done      = (r_state == S_DONE);
    count     = r_count;
    dbg_state = r_state;
  end

  // Output buffer and counters.
  always_comb begin
    w_head_nxt      = r_head;
    w_tail_nxt      = r_tail;
    w_occ_nxt       = r_occ;
    w_remaining_nxt = r_remaining;
    w_count_nxt     = r_count;

    case ({fifo_pop, w_xfer})
      2'b10: begin
        if (r_occ == 2'd0) w_head_nxt = fifo_data;
        else               w_tail_nxt = fifo_data;
        w_occ_nxt = r_occ + 2'd1;
      end
      2'b01: begin
        w_head_nxt = r_tail;
        w_tail_nxt = '0;
        w_occ_nxt  = r_occ - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: with one word the new word replaces the
        // head; with two, the tail advances and the new word takes its slot.
        if (r_occ == 2'd2) begin
          w_head_nxt = r_tail;
          w_tail_nxt = fifo_data;
        end else begin
          w_head_nxt = fifo_data;
        end
      end
      default: ;
    endcase

    if (fifo_pop) w_remaining_nxt = r_remaining - L_ONE;
    if (w_xfer)   w_count_nxt     = r_count + L_ONE;

    // An accepted start clears the delivered-word count of the last burst.
    if ((r_state == S_IDLE) && start) begin
      w_count_nxt = '0;
      if (burst_len != '0) w_remaining_nxt = burst_len;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (burst_len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (w_remaining_nxt == '0) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Look at next-state occupancy so the final transfer cycle itself
        // moves straight to DONE.
        if (w_occ_nxt == 2'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_count     <= '0;
      r_occ       <= 2'd0;
      r_head      <= '0;
      r_tail      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_count     <= w_count_nxt;
      r_occ       <= w_occ_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: an upstream FIFO source and a queue-based reference
// model of the burst reader, checked against the DUT on every falling edge,
// plus directed scenarios with literal expectations.
module tb_fifo_drain;
  localparam int W  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start, fifo_empty, fifo_pop, out_valid, out_ready, busy, done;
  logic [LW-1:0] burst_len, count;
  logic [W-1:0]  fifo_data, out_data;
  logic [1:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fifo_drain #(.WIDTH(W), .LENWID(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .count(count), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Upstream FIFO contents; gate_empty hides them to emulate an empty flag.
  logic [W-1:0] src_q[$];
  logic         gate_empty = 1'b0;

  // Reference model: burst phase (0 idle, 1 reading, 2 draining, 3 done),
  // words left to read, words delivered, and buffered words in order.
  int           m_phase = 0;
  int           m_rem   = 0;
  int           m_count = 0;
  logic [W-1:0] m_buf[$];

  // Scoreboard.
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int pop_seen, first_pop_cyc, last_pop_cyc, xfer_cyc;
  int done_seen, done_cyc, done_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_pop();
    return (m_phase == 1) && !fifo_empty && (m_rem != 0) && (m_buf.size() < 2);
  endfunction

  task automatic upd_src();
    fifo_empty = gate_empty || (src_q.size() == 0);
    if (src_q.size() != 0) fifo_data = src_q[0];
    else                   fifo_data = '0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_rem   = 0;
    m_count = 0;
    m_buf.delete();
  endtask

  // Model advance on the active edge; source pops follow the model.
  always @(posedge clk) begin : model_step
    bit p, x;
    cyc++;
    if (rst) begin
      p = m_pop();
      x = (m_buf.size() != 0) && out_ready;
      if (x) begin
        void'(m_buf.pop_front());
        m_count++;
      end
      if (p) begin
        m_buf.push_back(src_q.pop_front());
        m_rem--;
      end
      case (m_phase)
        0: if (start) begin
             m_count = 0;
             if (burst_len != 0) begin m_rem = int'(burst_len); m_phase = 1; end
             else m_phase = 3;
           end
        1: if (m_rem == 0) m_phase = 2;
        2: if (m_buf.size() == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  // Refresh the source view just after the edge so the DUT never races it.
  always @(posedge clk) begin
    #1;
    upd_src();
  end

  // Compare process.
  always @(negedge clk) begin
    chk("fifo_pop", {31'd0, fifo_pop}, {31'd0, m_pop()});
    chk("out_valid", {31'd0, out_valid}, (m_buf.size() != 0) ? 32'd1 : 32'd0);
    if (m_buf.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, m_buf[0]});
    else                   chk("out_data", {24'd0, out_data}, 32'd0);
    chk("busy", {31'd0, busy}, (m_phase == 1 || m_phase == 2) ? 32'd1 : 32'd0);
    chk("done", {31'd0, done}, (m_phase == 3) ? 32'd1 : 32'd0);
    chk("count", {28'd0, count}, m_count);
    if (fifo_pop) begin
      if (pop_seen == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pop_seen++;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      xfer_cyc = cyc;
    end
    if (done) begin
      done_seen  = 1;
      done_cyc   = cyc;
      done_count = int'(count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    pop_seen  = 0;
    done_seen = 0;
  endtask

  task automatic push_src(input logic [W-1:0] w);
    src_q.push_back(w);
    upd_src();
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    burst_len = LW'(len);
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!done_seen && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!done_seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_sb(input string name);
    chk({name, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_word"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 1'b0; burst_len = '0; out_ready = 1'b0;
    upd_src();
    clear_sb();
    #2 rst = 1'b0;
    tick();
    chk("rst_pop",   {31'd0, fifo_pop},  32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    chk("rst_count", {28'd0, count},     32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Burst of 4 with ready held high: back-to-back pops and transfers.
    clear_sb();
    push_src(8'hA1); push_src(8'hA2); push_src(8'hA3); push_src(8'hA4);
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    out_ready = 1'b1;
    do_start(4);
    wait_done("t1", 50);
    chk("t1_count", {28'd0, count}, 32'd4);
    chk("t1_pops", pop_seen, 32'd4);
    chk("t1_pop_span", last_pop_cyc - first_pop_cyc, 32'd3);
    chk("t1_done_lat", done_cyc, xfer_cyc + 1);
    check_sb("t1");
    tick(); tick();

    // Burst of 3 with downstream stalled: buffer fills to two then stops.
    clear_sb();
    push_src(8'hC1); push_src(8'hC2); push_src(8'hC3);
    exp_q = '{8'hC1, 8'hC2, 8'hC3};
    out_ready = 1'b0;
    do_start(3);
    repeat (5) tick();
    chk("t2_pops_stalled", pop_seen, 32'd2);
    chk("t2_pop_off", {31'd0, fifo_pop}, 32'd0);
    chk("t2_head", {24'd0, out_data}, 32'h0000_00C1);
    out_ready = 1'b1;
    wait_done("t2", 50);
    chk("t2_count", {28'd0, count}, 32'd3);
    check_sb("t2");
    tick(); tick();

    // Burst of 2 from an initially empty FIFO.
    clear_sb();
    exp_q = '{8'hB1, 8'hB2};
    out_ready = 1'b1;
    do_start(2);
    repeat (3) begin
      chk("t3_busy", {31'd0, busy}, 32'd1);
      chk("t3_no_pop", {31'd0, fifo_pop}, 32'd0);
      tick();
    end
    push_src(8'hB1); push_src(8'hB2);
    wait_done("t3", 50);
    chk("t3_pops", pop_seen, 32'd2);
    check_sb("t3");
    tick(); tick();

    // Zero-length burst, then start ignored while reading.
    clear_sb();
    do_start(0);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_count", {28'd0, count}, 32'd0);
    chk("t4_no_pop", {31'd0, fifo_pop}, 32'd0);
    tick();
    chk("t4_done_off", {31'd0, done}, 32'd0);
    clear_sb();
    push_src(8'hD1); push_src(8'hD2); push_src(8'hD3);
    exp_q = '{8'hD1, 8'hD2, 8'hD3};
    out_ready = 1'b0;
    do_start(3);
    start = 1'b1; burst_len = LW'(5);
    repeat (3) tick();
    start = 1'b0;
    out_ready = 1'b1;
    wait_done("t4", 50);
    chk("t4_count3", {28'd0, count}, 32'd3);
    check_sb("t4");
    tick(); tick();

    // Reset mid-burst with the buffer full.
    clear_sb();
    for (int i = 1; i <= 5; i++) push_src(8'hE0 + 8'(i));
    out_ready = 1'b1;
    do_start(5);
    tick(); tick();
    out_ready = 1'b0;
    tick();
    chk("t5_full_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_full_head", {24'd0, out_data}, 32'h0000_00E2);
    chk("t5_full_count", {28'd0, count}, 32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_busy",  {31'd0, busy},      32'd0);
    chk("t5_rst_count", {28'd0, count},     32'd0);
    chk("t5_rst_data",  {24'd0, out_data},  32'd0);
    done_seen = 0;
    src_q.delete();
    upd_src();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", done_seen, 32'd0);
    clear_sb();
    push_src(8'hF1); push_src(8'hF2);
    exp_q = '{8'hF1, 8'hF2};
    out_ready = 1'b1;
    do_start(2);
    wait_done("t5", 50);
    chk("t5_count", {28'd0, count}, 32'd2);
    check_sb("t5");
    tick(); tick();

    // Randomised ready and empty over many bursts.
    for (int b = 0; b < 200; b++) begin : rnd_burst
      int len, n;
      logic [W-1:0] w;
      clear_sb();
      len = $urandom_range(1, 15);
      for (int i = 0; i < len; i++) begin
        w = W'($urandom_range(0, 255));
        src_q.push_back(w);
        exp_q.push_back(w);
      end
      upd_src();
      out_ready = 1'($urandom_range(0, 1));
      do_start(len);
      n = 0;
      while (!done_seen && n < 600) begin
        out_ready  = 1'($urandom_range(0, 1));
        gate_empty = ($urandom_range(0, 3) == 0);
        upd_src();
        tick();
        n++;
      end
      gate_empty = 1'b0;
      upd_src();
      if (!done_seen) begin
        chk("rnd_timeout", 32'd0, 32'd1);
        break;
      end
      chk("rnd_count", done_count, len);
      check_sb("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter LENWID, default 4, width of burst length and delivered-word count.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset: asynchronous, active-low (rst==0 resets).
REQ-005 Port start  input  1  begin a burst; sampled only in IDLE.
REQ-006 Port burst_len  input  LENWID  number of words to read; sampled with start.
REQ-007 Port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 Port fifo_data  input  WIDTH  upstream FIFO head word, show-ahead: valid whenever fifo_empty==0.
REQ-009 Port fifo_pop  output  1  combinational pop strobe to the upstream FIFO.
REQ-010 Port out_valid  output  1  out_data holds a word.
REQ-011 Port out_ready  input  1  downstream accepts a word when out_valid&out_ready.
REQ-012 Port out_data  output  WIDTH  head of the internal output buffer.
REQ-013 Port busy  output  1  high in RUN and DRAIN.
REQ-014 Port done  output  1  one-cycle pulse at burst completion.
REQ-015 Port count  output  LENWID  words delivered downstream in the current burst.

Function
REQ-016 The block SHALL be an FSM with states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start==1 and burst_len!=0 SHALL load remaining=burst_len, clear count, go RUN.
REQ-018 IDLE: start==1 and burst_len==0 SHALL go DONE with no pop and count cleared.
REQ-019 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-020 fifo_pop SHALL equal (state==RUN) & ~fifo_empty & (remaining!=0) & (occ<2), where occ is output buffer occupancy (0..2).
REQ-021 On a pop cycle the fifo_data word SHALL be written into the buffer tail and remaining SHALL decrement by 1.
REQ-022 RUN SHALL go DRAIN on the cycle remaining becomes 0.
REQ-023 DRAIN SHALL go DONE when occ==0 (including same cycle the last word transfers out, evaluated on next-state occ).
REQ-024 DONE SHALL assert done for exactly one cycle, then go IDLE.
REQ-025 Output buffer SHALL be 2 entries, FIFO order; out_valid = (occ!=0); out_data = head entry.
REQ-026 A transfer (out_valid&out_ready) SHALL remove the head; simultaneous pop and transfer SHALL leave occ unchanged.
REQ-027 out_data SHALL be stable while out_valid==1 and out_ready==0.
REQ-028 Latency: word popped in cycle N SHALL be on out_data in cycle N+1 when occ was 0 at cycle N.
REQ-029 With out_ready held high and FIFO non-empty, throughput SHALL be 1 word/cycle.
REQ-030 count SHALL increment by 1 per transfer, hold after DONE until next accepted start; no wrap (max = burst_len).
REQ-031 fifo_pop SHALL never assert when fifo_empty==1 or outside RUN.
REQ-032 out_data SHALL be 0 when occ==0.

Reset
REQ-033 rst==0 SHALL immediately force state IDLE, occ=0, remaining=0, count=0, buffer entries 0.
REQ-034 During reset fifo_pop, out_valid, busy, done SHALL be 0 and out_data SHALL be 0.
REQ-035 Reset mid-burst SHALL abort the burst; buffered words are discarded, no done pulse.

Verification
REQ-036 Burst 4, FIFO holds A1..A4, out_ready=1 -> pops in 4 consecutive cycles, out_data A1..A4 one cycle later each, done 1 cycle after A4 transfer, count=4.
REQ-037 Burst 3, out_ready=0 for 5 cycles -> exactly 2 pops then fifo_pop=0, out_data=first word stable; releasing ready delivers all 3 in order, count=3.
REQ-038 Burst 2, fifo_empty=1 for 3 cycles then words B1,B2 -> no pop while empty, busy=1 throughout, B1,B2 delivered, done pulse.
REQ-039 start with burst_len=0 -> no pop, done pulse 1 cycle later, count=0; start during RUN ignored.
REQ-040 rst low mid-burst with occ=2 -> out_valid=0, busy=0, count=0 immediately (asynchronous), no done; new burst after release works.
REQ-041 Random out_ready and fifo_empty over 200 bursts of length 1..15 -> order preserved, no pop when empty, count==burst_len at each done.
